simple_axi_slave_mem: RTL and testbench
=======================================

Name: simple_axi_slave_mem

Overview:
- AXI4 responder: single-port word memory that terminates the transactions issued by the team's AXI4 master.
- Serves as the bench/bring-up target and as a small on-chip scratchpad.
- Handles one transaction at a time: full-width INCR bursts, SLVERR/DECERR error responses, programmable read latency.

Parameters:
- WIDTH, 32, data bus width in bits (32 or 64).
- DEPTH, 256, memory words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*WIDTH/8 aligned.
- RD_LATENCY, 1, cycles from AR handshake to first RVALID (1..15).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- s_axi_awvalid/awready  in/out  1/1  write address handshake
- s_axi_awaddr  in  32  write byte address
- s_axi_awsize  in  3  write beat size
- s_axi_awburst  in  2  write burst type
- s_axi_awlen  in  8  write beats minus 1
- s_axi_wvalid/wready  in/out  1/1  write data handshake
- s_axi_wdata  in  WIDTH  write data
- s_axi_wstrb  in  WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid/bready  out/in  1/1  write response handshake
- s_axi_bresp  out  2  write response
- s_axi_arvalid/arready  in/out  1/1  read address handshake
- s_axi_araddr  in  32  read byte address
- s_axi_arsize  in  3  read beat size
- s_axi_arburst  in  2  read burst type
- s_axi_arlen  in  8  read beats minus 1
- s_axi_rvalid/rready  out/in  1/1  read data handshake
- s_axi_rdata  out  WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: i_rst asynchronously forces state IDLE.
  - All ready/valid outputs 0; bresp, rresp, rdata = 0; rlast = 0; o_busy = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; beats already written persist.
- Ignored inputs: AWCACHE/PROT/LOCK/QOS are not ports.
- State machine: IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA.
- IDLE:
  - awready = 1; arready = ~awvalid. Write has priority when AWVALID and ARVALID are both high.
  - AW handshake: latch word index, len, error class -> WR_DATA.
  - AR handshake: latch the same for read, load latency counter = RD_LATENCY-1 -> RD_WAIT.
- Error classes, evaluated once at address handshake and applied to every beat of the burst:
  - SLVERR (2'b10): burst != INCR, or size != log2(WIDTH/8).
  - DECERR (2'b11): address outside [BASE_ADDR, BASE_ADDR+DEPTH*WIDTH/8), or the burst crosses the top of the memory.
  - SLVERR takes precedence over DECERR.
- Word index = (addr - BASE_ADDR) >> log2(WIDTH/8); low address bits are ignored (aligned). Index increments by 1 per beat.
- WR_DATA:
  - wready = 1. Each W handshake writes byte lanes selected by wstrb, only if the error class is OKAY.
  - A beat counter counts accepted beats.
  - On the beat where counter == len, or wlast = 1, go to WR_RESP.
  - wlast on a beat other than beat len: bresp becomes SLVERR. Beats after wlast are not accepted (the FSM has left WR_DATA).
- WR_RESP: bvalid = 1, bresp = latched class. Holds until bready, then -> IDLE. awready is 0 throughout.
- RD_WAIT: counter decrements each cycle; at 0 -> RD_DATA. With RD_LATENCY = 1, rvalid rises the cycle after the AR handshake.
- RD_DATA:
  - rvalid = 1; rdata = mem[index] (0 if error); rresp = class; rlast = (beat == len).
  - rdata, rresp and rlast are stable while rvalid && !rready.
  - On handshake, advance index/beat; after the rlast handshake -> IDLE. The next beat's data must be registered so that back-to-back beats run with no bubble when rready is held high.
- Memory read is a synchronous single-port RAM read with prefetch of the next beat; a write and a read never overlap.
- len = 255 is a full 256-beat burst; the beat counter is 8 bits with no wrap.

Decomposition:
- Package simple_axi_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR and BURST_FIXED/INCR/WRAP constants.
  - State enum.
- Sub-module simple_axi_slave_ram: byte-enable synchronous single-port RAM (WIDTH, DEPTH).

Test Plan:
- Single write: awaddr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, len 0, then read 0x10 -> bresp OKAY; rdata 0xDEADBEEF, rresp OKAY, rlast 1, rvalid exactly 1 cycle after AR handshake.
- Strobe write: wstrb 4'b0101, wdata 0x11223344 over 0xDEADBEEF, then read -> rdata 0xDE22BE44.
- INCR burst: write len 3 at 0x20 with data 1..4, read back with rready held 1 -> 4 consecutive rvalid cycles, data 1,2,3,4, rlast only on 4th; then rready toggled 1/0 -> data held stable while stalled.
- Errors:
  - awaddr BASE+DEPTH*4 -> bresp DECERR, memory unchanged.
  - arburst WRAP, len 1 -> two beats, both SLVERR, rdata 0, rlast on the 2nd.
- Contention: awvalid and arvalid asserted same cycle -> AW accepted first, arready 0 until the B handshake, then read served; RD_LATENCY = 4 -> rvalid exactly 4 cycles after the AR handshake.
- Reset mid-burst: assert i_rst during beat 2 of a len 7 write -> all outputs 0 immediately; after release, the next single read returns OKAY from IDLE.

Source files
------------

// File: rtl/simple_axi_pkg.sv
// Shared AXI response/burst encodings and the responder state encoding.
package simple_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_WAIT,
        RD_DATA
    } state_t;

endpackage

// File: rtl/simple_axi_slave_ram.sv
// Byte-enable single-port RAM with a registered (read-before-write) output.
module simple_axi_slave_ram
    import simple_axi_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [WIDTH/8-1:0]       wstrb,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    localparam int unsigned STRB_W = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we && wstrb[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/simple_axi_slave_mem.sv
// AXI4 responder over a word memory: one transaction at a time, INCR bursts,
// SLVERR/DECERR classification at the address phase, programmable read latency.
module simple_axi_slave_mem
    import simple_axi_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_awaddr,
    input  logic [2:0]         s_axi_awsize,
    input  logic [1:0]         s_axi_awburst,
    input  logic [7:0]         s_axi_awlen,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    input  logic [WIDTH-1:0]   s_axi_wdata,
    input  logic [WIDTH/8-1:0] s_axi_wstrb,
    input  logic               s_axi_wlast,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    output logic [1:0]         s_axi_bresp,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    input  logic [31:0]        s_axi_araddr,
    input  logic [2:0]         s_axi_arsize,
    input  logic [1:0]         s_axi_arburst,
    input  logic [7:0]         s_axi_arlen,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rlast,
    output logic               o_busy
);

    localparam int unsigned STRB_W    = WIDTH / 8;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned LSB       = $clog2(STRB_W);
    localparam logic [2:0]  BEAT_SIZE = 3'(LSB);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << LSB;
    localparam logic [32:0] MEM_WORDS = 33'(DEPTH);
    localparam logic [3:0]  LAT_INIT  = 4'(RD_LATENCY - 1);

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return AW'(off >> LSB);
    endfunction

    // 33-bit offset: an address below BASE wraps to >= 2^32 and lands in DECERR.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
        logic [32:0] off;
        logic [32:0] last_word;
        off       = {1'b0, addr} - {1'b0, BASE_ADDR};
        last_word = (off >> LSB) + {25'd0, len};
        if (burst != BURST_INCR || size != BEAT_SIZE) return RESP_SLVERR;
        if (off >= MEM_BYTES || last_word >= MEM_WORDS) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [7:0]       beat;
    logic [7:0]       len;
    logic [1:0]       cls;
    logic [3:0]       lat_cnt;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_q;

    assign s_axi_arready = s_axi_awready && !s_axi_awvalid;

    // RAM address runs one step ahead on reads so the next beat is already in ram_q.
    always_comb begin
        ram_addr = ptr;
        ram_we   = 1'b0;
        case (state)
            IDLE:    ram_addr = word_index(s_axi_araddr);
            WR_DATA: ram_we   = s_axi_wvalid && (cls == RESP_OKAY);
            RD_WAIT: if (lat_cnt == 4'd0) ram_addr = ptr + AW'(1);
            RD_DATA: if (s_axi_rready) ram_addr = ptr + AW'(1);
            default: ;
        endcase
    end

    simple_axi_slave_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (i_clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            ptr           <= '0;
            beat          <= '0;
            len           <= '0;
            cls           <= RESP_OKAY;
            lat_cnt       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_axi_awready <= 1'b1;
                    o_busy        <= 1'b0;
                    if (s_axi_awvalid && s_axi_awready) begin
                        ptr           <= word_index(s_axi_awaddr);
                        len           <= s_axi_awlen;
                        cls           <= classify(s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlen);
                        beat          <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        o_busy        <= 1'b1;
                        state         <= WR_DATA;
                    end else if (s_axi_arvalid && s_axi_arready) begin
                        ptr           <= word_index(s_axi_araddr);
                        len           <= s_axi_arlen;
                        cls           <= classify(s_axi_araddr, s_axi_arsize, s_axi_arburst, s_axi_arlen);
                        beat          <= '0;
                        lat_cnt       <= LAT_INIT;
                        s_axi_awready <= 1'b0;
                        o_busy        <= 1'b1;
                        state         <= RD_WAIT;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        ptr  <= ptr + AW'(1);
                        beat <= beat + 8'd1;
                        if (beat == len || s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (s_axi_wlast && beat != len) ? RESP_SLVERR : cls;
                            state        <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        o_busy        <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= (cls == RESP_OKAY) ? ram_q : '0;
                        s_axi_rresp  <= cls;
                        s_axi_rlast  <= (len == 8'd0);
                        ptr          <= ptr + AW'(1);
                        state        <= RD_DATA;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_awready <= 1'b1;
                            o_busy        <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            beat        <= beat + 8'd1;
                            ptr         <= ptr + AW'(1);
                            s_axi_rdata <= (cls == RESP_OKAY) ? ram_q : '0;
                            s_axi_rlast <= ((beat + 8'd1) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Directed bench for simple_axi_slave_mem: default instance (latency 1) plus a latency-4 instance.
module tb_simple_axi_slave_mem;
    import simple_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, busy;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;

    logic        l_awvalid, l_awready, l_wvalid, l_wready, l_wlast, l_bvalid, l_bready;
    logic        l_arvalid, l_arready, l_rvalid, l_rready, l_rlast, l_busy;
    logic [31:0] l_awaddr, l_araddr, l_wdata, l_rdata;
    logic [2:0]  l_awsize, l_arsize;
    logic [1:0]  l_awburst, l_arburst, l_bresp, l_rresp;
    logic [7:0]  l_awlen, l_arlen;
    logic [3:0]  l_wstrb;

    simple_axi_slave_mem dut (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast), .o_busy(busy)
    );

    simple_axi_slave_mem #(.RD_LATENCY(4)) dut_lat4 (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awvalid(l_awvalid), .s_axi_awready(l_awready), .s_axi_awaddr(l_awaddr),
        .s_axi_awsize(l_awsize), .s_axi_awburst(l_awburst), .s_axi_awlen(l_awlen),
        .s_axi_wvalid(l_wvalid), .s_axi_wready(l_wready), .s_axi_wdata(l_wdata),
        .s_axi_wstrb(l_wstrb), .s_axi_wlast(l_wlast),
        .s_axi_bvalid(l_bvalid), .s_axi_bready(l_bready), .s_axi_bresp(l_bresp),
        .s_axi_arvalid(l_arvalid), .s_axi_arready(l_arready), .s_axi_araddr(l_araddr),
        .s_axi_arsize(l_arsize), .s_axi_arburst(l_arburst), .s_axi_arlen(l_arlen),
        .s_axi_rvalid(l_rvalid), .s_axi_rready(l_rready), .s_axi_rdata(l_rdata),
        .s_axi_rresp(l_rresp), .s_axi_rlast(l_rlast), .o_busy(l_busy)
    );

    logic [31:0] wd   [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    int          rd_n, rd_lat, rd_gaps;

    task automatic timeout_fail(input string what);
        total++;
        bad++;
        $display("FAIL timeout_%s: handshake never completed", what);
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) timeout_fail("aw");
        else @(negedge clk);
        awvalid = 1'b0;
    endtask

    // Sends nbeats from wd[]; wlast is raised on beat last_at (-1: never).
    task automatic w_send(input int nbeats, input logic [3:0] strb, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wdata = wd[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) begin timeout_fail("w"); break; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) begin timeout_fail("b"); resp = 2'bxx; end
        else begin resp = bresp; @(negedge clk); end
        bready = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                               input logic [3:0] strb, output logic [1:0] resp);
        aw_send(addr, len, 3'd2, BURST_INCR);
        w_send(nbeats, strb, nbeats - 1);
        b_recv(resp);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) timeout_fail("ar");
        else @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Reads with rready held high; records beats, AR-to-RVALID latency and bubbles.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        int n = 0;
        ar_send(addr, len, size, burst);
        rready = 1'b1;
        while (!rvalid && k < 40) begin @(negedge clk); k++; end
        rd_lat = k; rd_n = 0; rd_gaps = 0;
        while (rd_n <= int'(len) && n < 600) begin
            if (rvalid) begin
                rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_n++;
            end else begin
                rd_gaps++;
            end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        if (rd_n <= int'(len)) timeout_fail("r");
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp, rdata});
        end
        total++;
        if ({l_awready, l_arready, l_rvalid, l_busy} !== 4'b0) begin
            bad++;
            $display("FAIL reset_lat4 got=%b want=0000", {l_awready, l_arready, l_rvalid, l_busy});
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({awready, arready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=110", {awready, arready, busy});
        end
    endtask

    task automatic test_single();
        logic [1:0] resp;
        wd[0] = 32'hDEADBEEF;
        write_burst(32'h10, 8'd0, 1, 4'hF, resp);
        total++;
        if (resp !== RESP_OKAY) begin bad++; $display("FAIL single_bresp got=%b want=%b", resp, RESP_OKAY); end
        read_burst(32'h10, 8'd0, 3'd2, BURST_INCR);
        total++;
        if (rd_d[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h want=deadbeef", rd_d[0]); end
        total++;
        if ({rd_r[0], rd_l[0]} !== 3'b001) begin bad++; $display("FAIL single_rresp_rlast got=%b want=001", {rd_r[0], rd_l[0]}); end
        total++;
        if (rd_lat !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", rd_lat); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        wd[0] = 32'h11223344;
        write_burst(32'h10, 8'd0, 1, 4'b0101, resp);
        read_burst(32'h10, 8'd0, 3'd2, BURST_INCR);
        total++;
        if (rd_d[0] !== 32'hDE22BE44) begin bad++; $display("FAIL strobe_rdata got=%h want=de22be44", rd_d[0]); end
    endtask

    task automatic test_burst();
        logic [1:0]  resp;
        logic        stalled = 1'b0;
        logic        tog = 1'b1;
        logic [31:0] held = '0;
        int          got = 0;
        int          stalls = 0;
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        write_burst(32'h20, 8'd3, 4, 4'hF, resp);
        total++;
        if (resp !== RESP_OKAY) begin bad++; $display("FAIL burst_bresp got=%b want=00", resp); end
        read_burst(32'h20, 8'd3, 3'd2, BURST_INCR);
        total++;
        if (rd_gaps !== 0 || rd_lat !== 1) begin
            bad++; $display("FAIL burst_bubbles got=gaps%0d/lat%0d want=gaps0/lat1", rd_gaps, rd_lat);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_d[i] !== 32'(i + 1) || rd_l[i] !== (i == 3)) begin
                bad++; $display("FAIL burst_beat%0d got=%h/%b want=%h/%b", i, rd_d[i], rd_l[i], i + 1, i == 3);
            end
        end
        // rready toggles every cycle; stalled beats must hold their data
        ar_send(32'h20, 8'd3, 3'd2, BURST_INCR);
        for (int c = 0; c < 40 && got < 4; c++) begin
            rready = tog;
            tog = ~tog;
            if (rvalid) begin
                if (stalled) begin
                    stalls++;
                    total++;
                    if (rdata !== held) begin bad++; $display("FAIL stall_hold got=%h want=%h", rdata, held); end
                end
                if (rready) begin
                    total++;
                    if (rdata !== 32'(got + 1)) begin bad++; $display("FAIL toggle_beat%0d got=%h want=%h", got, rdata, got + 1); end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = rdata;
                end
            end
            @(negedge clk);
        end
        rready = 1'b0;
        total++;
        if (got !== 4 || stalls == 0) begin bad++; $display("FAIL toggle_count got=%0d/%0d want=4/>0", got, stalls); end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        wd[0] = 32'hCAFEF00D;
        write_burst(32'h0, 8'd0, 1, 4'hF, resp);
        wd[0] = 32'h0BADBAD0;
        write_burst(32'h400, 8'd0, 1, 4'hF, resp);
        total++;
        if (resp !== RESP_DECERR) begin bad++; $display("FAIL decerr_bresp got=%b want=11", resp); end
        read_burst(32'h0, 8'd0, 3'd2, BURST_INCR);
        total++;
        if (rd_d[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL decerr_mem got=%h want=cafef00d", rd_d[0]); end
        read_burst(32'h20, 8'd1, 3'd2, BURST_WRAP);
        total++;
        if ({rd_r[0], rd_r[1], rd_l[0], rd_l[1]} !== 6'b101001 || rd_d[0] !== 0 || rd_d[1] !== 0) begin
            bad++; $display("FAIL wrap_slverr got=%b/%h/%h want=101001/0/0",
                            {rd_r[0], rd_r[1], rd_l[0], rd_l[1]}, rd_d[0], rd_d[1]);
        end
        read_burst(32'h3FC, 8'd1, 3'd2, BURST_INCR);
        total++;
        if ({rd_r[0], rd_r[1]} !== 4'b1111 || rd_d[0] !== 0) begin
            bad++; $display("FAIL cross_decerr got=%b/%h want=1111/0", {rd_r[0], rd_r[1]}, rd_d[0]);
        end
        read_burst(32'h400, 8'd0, 3'd3, BURST_INCR);
        total++;
        if (rd_r[0] !== RESP_SLVERR) begin bad++; $display("FAIL size_precedence got=%b want=10", rd_r[0]); end
        wd[0] = 32'hAAAA0001;
        wd[1] = 32'hBBBB0002;
        aw_send(32'h40, 8'd3, 3'd2, BURST_INCR);
        w_send(2, 4'hF, 1);
        b_recv(resp);
        total++;
        if (resp !== RESP_SLVERR) begin bad++; $display("FAIL early_wlast_bresp got=%b want=10", resp); end
        read_burst(32'h40, 8'd1, 3'd2, BURST_INCR);
        total++;
        if (rd_d[0] !== 32'hAAAA0001 || rd_d[1] !== 32'hBBBB0002 || rd_r[1] !== RESP_OKAY) begin
            bad++; $display("FAIL early_wlast_data got=%h/%h/%b want=aaaa0001/bbbb0002/00", rd_d[0], rd_d[1], rd_r[1]);
        end
    endtask

    task automatic test_contention();
        int k = 0;
        int n = 0;
        @(negedge clk);
        l_awaddr = 32'h30; l_awlen = 8'd0; l_awsize = 3'd2; l_awburst = BURST_INCR;
        l_araddr = 32'h30; l_arlen = 8'd0; l_arsize = 3'd2; l_arburst = BURST_INCR;
        l_awvalid = 1'b1; l_arvalid = 1'b1;
        #1;
        total++;
        if ({l_awready, l_arready} !== 2'b10) begin bad++; $display("FAIL contend_ready got=%b want=10", {l_awready, l_arready}); end
        @(negedge clk);
        l_awvalid = 1'b0;
        l_wdata = 32'h5A5AA5A5; l_wstrb = 4'hF; l_wlast = 1'b1; l_wvalid = 1'b1;
        #1;
        total++;
        if ({l_wready, l_arready} !== 2'b10) begin bad++; $display("FAIL contend_wphase got=%b want=10", {l_wready, l_arready}); end
        @(negedge clk);
        l_wvalid = 1'b0; l_wlast = 1'b0; l_bready = 1'b1;
        while (!l_bvalid && n < 50) begin @(negedge clk); n++; end
        total++;
        if (l_bvalid !== 1'b1 || l_arready !== 1'b0 || l_bresp !== RESP_OKAY) begin
            bad++; $display("FAIL contend_b got=%b%b%b want=1000", l_bvalid, l_arready, l_bresp);
        end
        @(negedge clk);
        l_bready = 1'b0;
        total++;
        if (l_arready !== 1'b1) begin bad++; $display("FAIL contend_ar_after_b got=%b want=1", l_arready); end
        @(negedge clk);
        l_arvalid = 1'b0; l_rready = 1'b1;
        while (!l_rvalid && k < 40) begin @(negedge clk); k++; end
        total++;
        if (k !== 4) begin bad++; $display("FAIL lat4_latency got=%0d want=4", k); end
        total++;
        if (l_rdata !== 32'h5A5AA5A5 || {l_rresp, l_rlast} !== 3'b001) begin
            bad++; $display("FAIL lat4_beat got=%h/%b want=5a5aa5a5/001", l_rdata, {l_rresp, l_rlast});
        end
        @(negedge clk);
        l_rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) wd[i] = 32'h100 + 32'(i);
        aw_send(32'h80, 8'd7, 3'd2, BURST_INCR);
        w_send(2, 4'hF, -1);
        wdata = wd[2]; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp, rdata} !== '0) begin
            bad++;
            $display("FAIL midburst_reset got=%h want=0",
                     {awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp, rdata});
        end
        @(negedge clk);
        wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        read_burst(32'h80, 8'd1, 3'd2, BURST_INCR);
        total++;
        if (rd_d[0] !== 32'h100 || rd_d[1] !== 32'h101 || rd_r[0] !== RESP_OKAY || rd_lat !== 1) begin
            bad++; $display("FAIL post_reset_read got=%h/%h/%b/%0d want=100/101/00/1", rd_d[0], rd_d[1], rd_r[0], rd_lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awsize = '0; arsize = '0; awburst = '0; arburst = '0; awlen = '0; arlen = '0;
        {l_awvalid, l_wvalid, l_wlast, l_bready, l_arvalid, l_rready} = '0;
        l_awaddr = '0; l_araddr = '0; l_wdata = '0; l_wstrb = '0;
        l_awsize = '0; l_arsize = '0; l_awburst = '0; l_arburst = '0; l_awlen = '0; l_arlen = '0;
        test_reset();
        test_single();
        test_strobe();
        test_burst();
        test_errors();
        test_contention();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
